// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle RV32 subset datapath
//                (R, I-ALU, LW, SW, BEQ/BNE, JAL, LUI) with a memory-wait
//                watchdog that parks the controller in a sticky FAULT state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [32:1] iInstr,
    input  logic        iZero,
    input  logic        iMemReady,
    output logic        oPCWrite,
    output logic        oPCSrc,
    output logic        oIRWrite,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oRegWrite,
    output logic [4:1]  oAluCtrl,
    output logic        oAluSrc,
    output logic [3:1]  oImmSrc,
    output logic [2:1]  oResultSrc,
    output logic [3:1]  oState,
    output logic        oFault
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_FAULT  = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BR  = 3'd4,
        CLS_JAL = 3'd5,
        CLS_LUI = 3'd6
    } cls_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Instruction field extraction (port is numbered from bit 1)
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       unused_instr_bits;

    assign w_opcode   = iInstr[7:1];
    assign w_funct3   = iInstr[15:13];
    assign w_funct7b5 = iInstr[31];
    assign unused_instr_bits = ^{iInstr[32], iInstr[30:16], iInstr[12:8]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    cls_t             cls_q,    cls_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             f7b5_q,   f7b5_d;

    // ALU operation for R/I-type arithmetic; SUB only exists for R-type
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       f7b5,
                                                  input logic       allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            3'b010:  op = ALU_SLT;
            3'b001:  op = ALU_SLL;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Next-state, wait counter and decoded-instruction capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cls_d    = cls_q;
        funct3_d = funct3_q;
        f7b5_d   = f7b5_q;

        case (state_q)
            S_FETCH: begin
                if (iMemReady) begin
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                // Capture the decode so later states do not depend on iInstr
                funct3_d = w_funct3;
                f7b5_d   = w_funct7b5;
                state_d  = S_EXEC;
                case (w_opcode)
                    OP_R:    cls_d = CLS_R;
                    OP_I:    cls_d = CLS_I;
                    OP_LW:   cls_d = CLS_LW;
                    OP_SW:   cls_d = CLS_SW;
                    OP_BR:   cls_d = CLS_BR;
                    OP_JAL:  cls_d = CLS_JAL;
                    OP_LUI:  cls_d = CLS_LUI;
                    default: state_d = S_FAULT;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I, CLS_LUI: state_d = S_WB;
                    CLS_LW, CLS_SW: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    CLS_BR: begin
                        if (funct3_q == 3'b000 || funct3_q == 3'b001) begin
                            state_d = S_FETCH;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                    CLS_JAL: begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            S_MEM: begin
                if (iMemReady) begin
                    if (cls_q == CLS_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end

            S_FAULT: state_d = S_FAULT;

            default: state_d = S_FAULT;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            cls_q    <= CLS_R;
            funct3_q <= 3'b000;
            f7b5_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cls_q    <= cls_d;
            funct3_q <= funct3_d;
            f7b5_q   <= f7b5_d;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs: decoded from current state, latched class and the
    // same-cycle handshake/zero inputs
    // ------------------------------------------------------------------
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       in_datapath;

    assign in_datapath = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    // Per-state strobes and per-class datapath selects
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        result_src = RES_ALU;

        // Selects stay stable across EXEC/MEM/WB so the datapath result holds
        if (in_datapath) begin
            case (cls_q)
                CLS_R:   alu_ctrl = alu_from_funct(funct3_q, f7b5_q, 1'b1);
                CLS_I: begin
                    alu_ctrl = alu_from_funct(funct3_q, f7b5_q, 1'b0);
                    alu_src  = 1'b1;
                end
                CLS_LW:  alu_src = 1'b1;
                CLS_SW: begin
                    alu_src = 1'b1;
                    imm_src = IMM_S;
                end
                CLS_BR: begin
                    alu_ctrl = ALU_SUB;
                    imm_src  = IMM_B;
                end
                CLS_JAL: imm_src = IMM_J;
                CLS_LUI: begin
                    alu_ctrl = ALU_PASSB;
                    alu_src  = 1'b1;
                    imm_src  = IMM_U;
                end
                default: alu_ctrl = ALU_ADD;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (iMemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                if (cls_q == CLS_BR) begin
                    pc_src = 1'b1;
                    if (funct3_q == 3'b000) begin
                        pc_write = iZero;
                    end else if (funct3_q == 3'b001) begin
                        pc_write = !iZero;
                    end
                end else if (cls_q == CLS_JAL) begin
                    pc_src     = 1'b1;
                    pc_write   = 1'b1;
                    result_src = RES_PC4;
                    reg_write  = 1'b1;
                end
            end
            S_MEM: begin
                mem_read  = (cls_q == CLS_LW);
                mem_write = (cls_q == CLS_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                result_src = (cls_q == CLS_LW) ? RES_MEM : RES_ALU;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Reset low must silence everything immediately, even FETCH's read strobe
    assign oPCWrite   = iRstN & pc_write;
    assign oPCSrc     = iRstN & pc_src;
    assign oIRWrite   = iRstN & ir_write;
    assign oMemRead   = iRstN & mem_read;
    assign oMemWrite  = iRstN & mem_write;
    assign oRegWrite  = iRstN & reg_write;
    assign oAluCtrl   = iRstN ? alu_ctrl   : 4'b0000;
    assign oAluSrc    = iRstN & alu_src;
    assign oImmSrc    = iRstN ? imm_src    : 3'b000;
    assign oResultSrc = iRstN ? result_src : 2'b00;
    assign oState     = state_q;
    assign oFault     = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic [32:1] iInstr = '0;
    logic        iZero = 1'b0;
    logic        iMemReady = 1'b0;
    logic        oPCWrite, oPCSrc, oIRWrite, oMemRead, oMemWrite, oRegWrite;
    logic [4:1]  oAluCtrl;
    logic        oAluSrc;
    logic [3:1]  oImmSrc;
    logic [2:1]  oResultSrc;
    logic [3:1]  oState;
    logic        oFault;
    logic [4:0]  strb;

    int n_total = 0;
    int n_bad   = 0;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16)) u_dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iInstr     (iInstr),
        .iZero      (iZero),
        .iMemReady  (iMemReady),
        .oPCWrite   (oPCWrite),
        .oPCSrc     (oPCSrc),
        .oIRWrite   (oIRWrite),
        .oMemRead   (oMemRead),
        .oMemWrite  (oMemWrite),
        .oRegWrite  (oRegWrite),
        .oAluCtrl   (oAluCtrl),
        .oAluSrc    (oAluSrc),
        .oImmSrc    (oImmSrc),
        .oResultSrc (oResultSrc),
        .oState     (oState),
        .oFault     (oFault)
    );

    // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    assign strb = {oPCWrite, oIRWrite, oMemRead, oMemWrite, oRegWrite};

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, land 2 time units after the rising edge
    task automatic tick();
        @(posedge iClk);
        #2;
    endtask

    // Reset pulse entirely between clock edges
    task automatic rst_pulse();
        iRstN = 1'b0;
        #1;
        chk("rst_state", oState, 3'b000);
        chk("rst_fault", oFault, 1'b0);
        chk("rst_strb",  strb,   5'b00000);
        #1;
        iRstN = 1'b1;
        #1;
    endtask

    // From FETCH with memory ready: go through DECODE into EXEC
    task automatic go_exec(input logic [31:0] instr);
        iInstr    = instr;
        iMemReady = 1'b1;
        #1;
        chk("fetch_strb", strb, 5'b11100);
        chk("fetch_pcsrc", oPCSrc, 1'b0);
        tick();
        chk("dec_state", oState, 3'b001);
        chk("dec_strb",  strb,   5'b00000);
        tick();
        chk("exec_state", oState, 3'b010);
    endtask

    initial begin
        // ---- reset state (ready high to prove FETCH strobes are gated) ----
        iMemReady = 1'b1;
        #12;
        chk("inrst_state", oState, 3'b000);
        chk("inrst_strb",  strb,   5'b00000);
        chk("inrst_alu",   oAluCtrl, 4'b0000);
        chk("inrst_fault", oFault, 1'b0);
        tick();
        iRstN = 1'b1;
        #1;
        chk("post_rst_state", oState, 3'b000);

        // ---- ADD x3,x1,x2 ----
        go_exec(32'h002081B3);
        chk("add_alu",  oAluCtrl, 4'b0000);
        chk("add_src",  oAluSrc,  1'b0);
        chk("add_strb", strb,     5'b00000);
        tick();
        chk("add_wb_state", oState, 3'b100);
        chk("add_wb_strb",  strb,   5'b00001);
        chk("add_wb_res",   oResultSrc, 2'b00);
        tick();
        chk("add_back_fetch", oState, 3'b000);

        // ---- SUB ----
        go_exec(32'h402081B3);
        chk("sub_alu", oAluCtrl, 4'b0001);
        tick(); tick();

        // ---- SRAI x3,x1,3 ----
        go_exec(32'h4030D193);
        chk("srai_alu", oAluCtrl, 4'b1000);
        chk("srai_src", oAluSrc,  1'b1);
        tick(); tick();

        // ---- LUI ----
        go_exec(32'h000011B7);
        chk("lui_alu", oAluCtrl, 4'b1001);
        chk("lui_imm", oImmSrc,  3'b100);
        chk("lui_src", oAluSrc,  1'b1);
        tick();
        chk("lui_wb_strb", strb, 5'b00001);
        tick();

        // ---- LW with three wait cycles in MEM ----
        go_exec(32'h0000A183);
        chk("lw_src", oAluSrc, 1'b1);
        chk("lw_imm", oImmSrc, 3'b000);
        iMemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_mem_state", oState, 3'b011);
            chk("lw_mem_wait",  strb,   5'b00100);
        end
        tick();
        iMemReady = 1'b1;
        #1;
        chk("lw_mem_done", strb, 5'b00100);
        tick();
        chk("lw_wb_state", oState,     3'b100);
        chk("lw_wb_res",   oResultSrc, 2'b01);
        chk("lw_wb_strb",  strb,       5'b00001);
        tick();
        chk("lw_back_fetch", oState, 3'b000);

        // ---- BEQ taken / not taken, BNE taken ----
        iZero = 1'b1;
        go_exec(32'h00208463);
        chk("beq1_pcw",   oPCWrite, 1'b1);
        chk("beq1_pcsrc", oPCSrc,   1'b1);
        chk("beq1_alu",   oAluCtrl, 4'b0001);
        chk("beq1_imm",   oImmSrc,  3'b010);
        tick();
        chk("beq1_fetch", oState, 3'b000);
        iZero = 1'b0;
        go_exec(32'h00208463);
        chk("beq0_pcw",   oPCWrite, 1'b0);
        chk("beq0_pcsrc", oPCSrc,   1'b1);
        tick();
        go_exec(32'h00209463);
        chk("bne0_pcw", oPCWrite, 1'b1);
        tick();

        // ---- JAL ----
        go_exec(32'h008000EF);
        chk("jal_strb", strb,       5'b10001);
        chk("jal_res",  oResultSrc, 2'b10);
        chk("jal_imm",  oImmSrc,    3'b011);
        chk("jal_pcsrc", oPCSrc,    1'b1);
        tick();
        chk("jal_fetch", oState, 3'b000);

        // ---- branch with unsupported funct3 ----
        go_exec(32'h0020A463);
        chk("bbad_pcw", oPCWrite, 1'b0);
        tick();
        chk("bbad_state", oState, 3'b111);
        chk("bbad_fault", oFault, 1'b1);
        rst_pulse();

        // ---- SW: reset asserted mid-MEM drops the write strobe at once ----
        go_exec(32'h0020A023);
        chk("sw_imm", oImmSrc, 3'b001);
        iMemReady = 1'b0;
        tick();
        chk("sw_mem_strb", strb, 5'b00010);
        tick();
        chk("sw_mem_hold", strb, 5'b00010);
        #2;
        iRstN = 1'b0;
        #1;
        chk("sw_async_strb",  strb,   5'b00000);
        chk("sw_async_state", oState, 3'b000);
        #1;
        iRstN = 1'b1;

        // ---- FETCH timeout: 16 tolerated wait cycles, fault on the next ----
        tick();
        repeat (15) tick();
        chk("to_edge_state", oState,   3'b000);
        chk("to_edge_mr",    oMemRead, 1'b1);
        tick();
        chk("to_state", oState, 3'b111);
        chk("to_fault", oFault, 1'b1);
        chk("to_strb",  strb,   5'b00000);
        tick(); tick();
        chk("to_sticky", oFault, 1'b1);
        rst_pulse();
        chk("to_rst_fault", oFault, 1'b0);

        // ---- ready in the last tolerated cycle wins; then opcode 0x7F ----
        iInstr    = 32'h0000007F;
        iMemReady = 1'b0;
        repeat (16) tick();
        iMemReady = 1'b1;
        #1;
        chk("edge_ready_strb", strb, 5'b11100);
        tick();
        chk("edge_ready_state", oState, 3'b001);
        chk("edge_ready_fault", oFault, 1'b0);
        tick();
        chk("badop_state", oState, 3'b111);
        chk("badop_fault", oFault, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, memory-wait cycles tolerated before fault.
REQ-002 iClk  in  1  single clock; all state changes on its rising edge.
REQ-003 iRstN  in  1  reset, asynchronous assert, active-low.
REQ-004 iInstr  in  [32:1]  instruction word from instruction memory; opcode iInstr[7:1], funct3 iInstr[15:13], funct7[5] iInstr[31].
REQ-005 iZero  in  1  ALU zero flag.
REQ-006 iMemReady  in  1  memory handshake; access completes in a cycle where it is high.
REQ-007 oPCWrite  out  1  PC register load enable.
REQ-008 oPCSrc  out  1  0 = PC+4, 1 = branch/jump target.
REQ-009 oIRWrite  out  1  instruction register load enable.
REQ-010 oMemRead / oMemWrite  out  1 each  data memory strobes.
REQ-011 oRegWrite  out  1  register file write enable.
REQ-012 oAluCtrl  out  [4:1]  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 PASSB.
REQ-013 oAluSrc  out  1  0 = rs2, 1 = immediate.
REQ-014 oImmSrc  out  [3:1]  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-015 oResultSrc  out  [2:1]  00 ALU, 01 memory, 10 PC+4.
REQ-016 oState  out  [3:1]  current state: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, FAULT 111.
REQ-017 oFault  out  1  sticky fault flag.

Function
REQ-018 FETCH: oMemRead=1; on iMemReady=1 assert oIRWrite=1, oPCWrite=1, oPCSrc=0 for that cycle and go to DECODE; else stay.
REQ-019 DECODE: one cycle, no strobes; supported opcodes 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE, 1101111 JAL, 0110111 LUI -> EXEC; any other opcode -> FAULT.
REQ-020 EXEC R/I-ALU: oAluCtrl from funct3 (000 ADD, or SUB if R and funct7[5]; 100 XOR; 110 OR; 111 AND; 010 SLT; 001 SLL; 101 SRL/SRA by funct7[5]); oAluSrc=1 for I-ALU; -> WB.
REQ-021 EXEC LW/SW: oAluCtrl=ADD, oAluSrc=1, oImmSrc I (LW) or S (SW); -> MEM.
REQ-022 EXEC BEQ/BNE: oAluCtrl=SUB, oImmSrc=B, oPCSrc=1, oPCWrite=iZero (funct3 000) or !iZero (funct3 001); other funct3 -> FAULT; else -> FETCH.
REQ-023 EXEC JAL: oImmSrc=J, oPCSrc=1, oPCWrite=1, oResultSrc=10, oRegWrite=1; -> FETCH.
REQ-024 EXEC LUI: oImmSrc=U, oAluSrc=1, oAluCtrl=PASSB; -> WB.
REQ-025 MEM: oMemRead=1 (LW) or oMemWrite=1 (SW) held until iMemReady=1; then LW -> WB with oResultSrc=01, SW -> FETCH.
REQ-026 WB: oRegWrite=1 for exactly one cycle, oResultSrc held from instruction class; -> FETCH.
REQ-027 Wait counter: cleared on entry to FETCH or MEM, increments each cycle iMemReady=0 there; reaching TIMEOUT_CYCLES -> FAULT.
REQ-028 iMemReady=1 in the same cycle the counter reaches TIMEOUT_CYCLES: completion wins, no fault.
REQ-029 FAULT: oFault=1, all strobes 0; exit only by reset.
REQ-030 Strobes (oPCWrite, oIRWrite, oMemRead, oMemWrite, oRegWrite) are 0 in every state/condition not listed above.
REQ-031 Latencies with zero-wait memory: R/I/LUI 4 cycles, LW 5, SW 4, branch/JAL 3.

Reset
REQ-032 iRstN=0 immediately forces state FETCH, counter 0, oFault=0, all strobes 0, oAluCtrl/oImmSrc/oResultSrc/oAluSrc/oPCSrc 0, even mid-instruction.
REQ-033 First state advance occurs on the first rising iClk edge after iRstN=1.

Verification
REQ-034 ADD x3,x1,x2 (0x002081B3), iMemReady=1 -> states 000,001,010,100,000; oAluCtrl=0000 in EXEC; oRegWrite=1 only in WB.
REQ-035 LW 0x0000A183, iMemReady low 3 cycles in MEM -> oMemRead held 4 cycles, then WB with oResultSrc=01.
REQ-036 BEQ with iZero=1 -> oPCWrite=1, oPCSrc=1 in EXEC; repeat iZero=0 -> oPCWrite=0.
REQ-037 iMemReady=0 forever in FETCH -> FAULT after 16 cycles, oFault=1, strobes 0; iRstN pulse -> FETCH, oFault=0.
REQ-038 Opcode 0x7F in DECODE -> FAULT; iRstN low mid-MEM of SW -> oMemWrite drops without waiting for iClk.
